// File: rtl/y_mux4_arbiter_if.sv
// y_mux4_arbiter_if: bundle of the four requester ports and the single consumer port.
// The in_last vector only exists when the design is built with ARB_BURST_EN.
// The slave modport is the arbiter's view; the master modport is the producer/consumer side.
interface y_mux4_arbiter_if #(
  parameter int SIZE = 32
);
  logic [3:0]      in_req;
  logic [SIZE-1:0] in_data0;
  logic [SIZE-1:0] in_data1;
  logic [SIZE-1:0] in_data2;
  logic [SIZE-1:0] in_data3;
`ifdef ARB_BURST_EN
  logic [3:0]      in_last;
`endif
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [SIZE-1:0] out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  logic            busy;

`ifdef ARB_BURST_EN
  modport master (
    output in_req, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_src, busy
  );
  modport slave (
    input  in_req, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
    output in_ready, out_valid, out_data, out_src, busy
  );
`else
  modport master (
    output in_req, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_src, busy
  );
  modport slave (
    input  in_req, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_src, busy
  );
`endif
endinterface

// File: rtl/y_mux4_arbiter.sv
// y_mux4_arbiter: round-robin arbiter sharing one SIZE-wide 4:1 word mux among four
// requesters. A winner is picked in IDLE, its word is captured through the mux in GRANT,
// and the captured word is offered downstream with valid/ready in OUT.
// Build option: define ARB_BURST_EN to add in_last and lock the grant across a burst.

// YMux4: plain 4-to-1 word multiplexer.
module YMux4 #(
  parameter int SIZE = 32
) (
  input  logic [1:0]      i_sel,
  input  logic [SIZE-1:0] i_d0,
  input  logic [SIZE-1:0] i_d1,
  input  logic [SIZE-1:0] i_d2,
  input  logic [SIZE-1:0] i_d3,
  output logic [SIZE-1:0] o_y
);
  // Select one of the four words.
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end
endmodule

module y_mux4_arbiter #(
  parameter int SIZE = 32
) (
  input logic               clk,
  input logic               rst_n,
  y_mux4_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [1:0]      r_sel;
  logic [1:0]      r_ptr;
  logic [1:0]      w_winner;
  logic            w_anyReq;
  logic            w_grantOk;
  logic [SIZE-1:0] w_muxData;
  logic [SIZE-1:0] r_outData;
  logic [1:0]      r_outSrc;
`ifdef ARB_BURST_EN
  logic            r_last;
`endif

  YMux4 #(.SIZE(SIZE)) u_mux (
    .i_sel (r_sel),
    .i_d0  (bus.in_data0),
    .i_d1  (bus.in_data1),
    .i_d2  (bus.in_data2),
    .i_d3  (bus.in_data3),
    .o_y   (w_muxData)
  );

  // Round-robin scan starting just after the last winner; walking k downwards lets the
  // closest requester to ptr+1 overwrite the others.
  always_comb begin
    w_winner = 2'd0;
    w_anyReq = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (bus.in_req[r_ptr + 2'(k)]) begin
        w_winner = r_ptr + 2'(k);
        w_anyReq = 1'b1;
      end
    end
  end

  // The granted requester still holds its request, so its word can be taken this cycle.
  assign w_grantOk = (r_state == GRANT) && bus.in_req[r_sel];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a withdrawn request in GRANT falls back to IDLE without capture.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_nextState = GRANT;
        end
      end
      GRANT: begin
        if (w_grantOk) begin
          w_nextState = OUT;
        end else begin
          w_nextState = IDLE;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
`ifdef ARB_BURST_EN
          w_nextState = r_last ? IDLE : GRANT;
`else
          w_nextState = IDLE;
`endif
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Select, pointer and output word registers; the word is held untouched through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= 2'd0;
      r_ptr     <= 2'd3;
      r_outData <= '0;
      r_outSrc  <= 2'd0;
`ifdef ARB_BURST_EN
      r_last    <= 1'b1;
`endif
    end else begin
      if ((r_state == IDLE) && w_anyReq) begin
        r_sel <= w_winner;
      end
      if (w_grantOk) begin
        r_outData <= w_muxData;
        r_outSrc  <= r_sel;
        r_ptr     <= r_sel;
`ifdef ARB_BURST_EN
        r_last    <= bus.in_last[r_sel];
`endif
      end
    end
  end

  assign bus.in_ready  = w_grantOk ? (4'b0001 << r_sel) : 4'b0000;
  assign bus.out_valid = (r_state == OUT);
  assign bus.out_data  = r_outData;
  assign bus.out_src   = r_outSrc;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_y_mux4_arbiter.sv
// tb_y_mux4_arbiter: directed scoreboard bench for y_mux4_arbiter.
// Stimulus pushes expected grants and output words into queues; a negedge monitor pops
// and compares them whenever in_ready pulses or an output handshake is about to happen.
// Build with ARB_BURST_EN defined to include the burst-lock scenario.
module tb_y_mux4_arbiter;
  localparam int SIZE = 32;

  typedef struct packed {
    logic [1:0]      src;
    logic [SIZE-1:0] data;
  } outExp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  y_mux4_arbiter_if #(.SIZE(SIZE)) bus ();

  y_mux4_arbiter #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  outExp_t expOut[$];
  int      expGrant[$];
  int      grantCount = 0;
  int      assertCount = 0;
  int      failCount = 0;
  int      monGrant;
  outExp_t monOut;

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic outRdy);
    bus.in_req    = req;
    bus.out_ready = outRdy;
  endtask

  task automatic applyReset();
    rst_n         = 1'b0;
    bus.in_req    = 4'b0000;
    bus.out_ready = 1'b0;
    bus.in_data0  = '0;
    bus.in_data1  = '0;
    bus.in_data2  = '0;
    bus.in_data3  = '0;
`ifdef ARB_BURST_EN
    bus.in_last   = 4'b1111;
`endif
    expOut.delete();
    expGrant.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset out_data", 64'(bus.out_data), 64'd0);
    checkOutput("reset out_src", 64'(bus.out_src), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.in_ready == 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready == 4'b0000) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: in_ready never seen, got %0h, expected nonzero", name, bus.in_ready);
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    @(negedge clk);
    while ((expOut.size() != 0 || expGrant.size() != 0 || bus.busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (expOut.size() != 0 || expGrant.size() != 0 || bus.busy) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: pending words %0d grants %0d, expected 0 0", name,
               expOut.size(), expGrant.size());
    end
  endtask

  // Scoreboard monitor: checks every in_ready pulse and every output word at handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_ready != 4'b0000) begin
        grantCount++;
        if (expGrant.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected in_ready: got %0h, expected 0", bus.in_ready);
        end else begin
          monGrant = expGrant.pop_front();
          checkOutput("in_ready grant", 64'(bus.in_ready), 64'(4'b0001 << monGrant));
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expOut.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected output: got src %0d data %0h, expected none",
                   bus.out_src, bus.out_data);
        end else begin
          monOut = expOut.pop_front();
          checkOutput("out_src", 64'(bus.out_src), 64'(monOut.src));
          checkOutput("out_data", 64'(bus.out_data), 64'(monOut.data));
        end
      end
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int g0;

    // Reset then idle.
    applyReset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("idle in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("idle busy", 64'(bus.busy), 64'd0);
    end

    // Single request from requester 2.
    applyReset();
    bus.in_data2 = 32'hDEADBEEF;
    expGrant.push_back(2);
    expOut.push_back('{src: 2'd2, data: 32'hDEADBEEF});
    applyStimulus(4'b0100, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("single in_ready latency", 64'(bus.in_ready), 64'h4);
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("single out_valid latency", 64'(bus.out_valid), 64'd1);
    checkOutput("single out_data", 64'(bus.out_data), 64'hDEADBEEF);
    waitDrain("single drain");

    // Fairness with all four requesting continuously.
    applyReset();
    bus.in_data0 = 32'd1;
    bus.in_data1 = 32'd2;
    bus.in_data2 = 32'd3;
    bus.in_data3 = 32'd4;
    for (int r = 0; r < 8; r++) begin
      expGrant.push_back(r % 4);
      expOut.push_back('{src: 2'(r % 4), data: 32'((r % 4) + 1)});
    end
    applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      waitReady("fair grant");
    end
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b1);
    waitDrain("fair drain");

    // Back-pressure: word held for five stalled cycles.
    applyReset();
    bus.in_data0 = 32'hA5A5_0001;
    expGrant.push_back(0);
    expOut.push_back('{src: 2'd0, data: 32'hA5A5_0001});
    g0 = grantCount;
    applyStimulus(4'b0001, 1'b0);
    waitReady("stall grant");
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall out_data", 64'(bus.out_data), 64'hA5A5_0001);
    end
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b1);
    waitDrain("stall drain");
    checkOutput("stall single in_ready", 64'(grantCount - g0), 64'd1);

    // Withdrawal during GRANT, then 1 wins over 3.
    applyReset();
    bus.in_data1 = 32'h0000_1111;
    bus.in_data3 = 32'h0000_3333;
    g0 = grantCount;
    applyStimulus(4'b0010, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("withdraw in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("withdraw busy in GRANT", 64'(bus.busy), 64'd1);
    @(negedge clk);
    checkOutput("withdraw back to IDLE", 64'(bus.busy), 64'd0);
    checkOutput("withdraw no grant", 64'(grantCount - g0), 64'd0);
    expGrant.push_back(1);
    expOut.push_back('{src: 2'd1, data: 32'h0000_1111});
    @(posedge clk);
    #1;
    applyStimulus(4'b1010, 1'b1);
    waitReady("withdraw regrant");
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b1);
    waitDrain("withdraw drain");

    // Asynchronous reset while a word is held in OUT.
    applyReset();
    bus.in_data0 = 32'hCAFE_0000;
    expGrant.push_back(0);
    applyStimulus(4'b0001, 1'b0);
    waitReady("async grant");
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("async out_valid before reset", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async out_valid after reset", 64'(bus.out_valid), 64'd0);
    checkOutput("async busy after reset", 64'(bus.busy), 64'd0);
    checkOutput("async out_data after reset", 64'(bus.out_data), 64'd0);

`ifdef ARB_BURST_EN
    // Burst lock: requester 0 sends three words before requester 1 is served.
    applyReset();
    bus.in_data0 = 32'h1000_0000;
    bus.in_data1 = 32'h1111_1111;
    bus.in_data2 = 32'h2222_2222;
    bus.in_data3 = 32'h3333_3333;
    bus.in_last  = 4'b1110;
    expGrant.push_back(0);
    expGrant.push_back(0);
    expGrant.push_back(0);
    expGrant.push_back(1);
    expOut.push_back('{src: 2'd0, data: 32'h1000_0000});
    expOut.push_back('{src: 2'd0, data: 32'h1000_0001});
    expOut.push_back('{src: 2'd0, data: 32'h1000_0002});
    expOut.push_back('{src: 2'd1, data: 32'h1111_1111});
    applyStimulus(4'b1111, 1'b1);
    waitReady("burst word0");
    @(posedge clk);
    #1;
    bus.in_data0 = 32'h1000_0001;
    waitReady("burst word1");
    @(posedge clk);
    #1;
    bus.in_data0   = 32'h1000_0002;
    bus.in_last[0] = 1'b1;
    waitReady("burst word2");
    @(posedge clk);
    #1;
    applyStimulus(4'b1110, 1'b1);
    waitReady("burst next winner");
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b1);
    waitDrain("burst drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
